// File: rtl/tower_event_collector.sv
// Calorimeter tower event collector: threshold-filters a tower stream into a dense buffer,
// freezes it at end of event and hands it to the sorter. Optional macro: TOWER_E_CHECK_EN.
module tower_event_collector #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_eta,
    input  logic [W-1:0]  in_phi,
    input  logic [W-1:0]  in_et,
    input  logic [W-1:0]  in_e,
    input  logic          in_last,
    input  logic [W-1:0]  threshold,
    output logic [AW:0]   numtowers,
    output logic          order,
    output logic          overflow,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_eta,
    output logic [W-1:0]  rd_phi,
    output logic [W-1:0]  rd_et,
    output logic [W-1:0]  rd_e,
    input  logic          ack
);

    localparam int unsigned RW   = 4 * W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_COLLECT, S_HOLD} state_t;

    state_t        r_state;
    logic          r_in_ready;
    logic [AW:0]   r_count;
    logic          r_order;
    logic          r_overflow;
    logic [RW-1:0] r_mem [DEPTH];
    logic [RW-1:0] r_rd_data;

    logic w_accept;
    logic w_keep;
    logic w_wr;

    // Beat qualification; a malformed tower (E below Et) is dropped when the check is built in.
    always_comb begin
        w_accept = in_valid && r_in_ready;
`ifdef TOWER_E_CHECK_EN
        w_keep   = (in_et >= threshold) && (in_e >= in_et);
`else
        w_keep   = (in_et >= threshold);
`endif
        w_wr     = w_accept && w_keep && (r_count != FULL);
    end

    // Collect/hold control; in_ready stays low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_COLLECT;
            r_in_ready <= 1'b0;
            r_count    <= '0;
            r_order    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_order <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_keep) begin
                            if (r_count != FULL) begin
                                r_count <= r_count + (AW+1)'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (in_last) begin
                            r_state    <= S_HOLD;
                            r_in_ready <= 1'b0;
                            r_order    <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (ack) begin
                        r_state    <= S_COLLECT;
                        r_in_ready <= 1'b1;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_COLLECT;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Event buffer storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_count[AW-1:0]] <= {in_eta, in_phi, in_et, in_e};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign in_ready  = r_in_ready;
    assign numtowers = r_count;
    assign order     = r_order;
    assign overflow  = r_overflow;
    assign rd_eta    = r_rd_data[4*W-1:3*W];
    assign rd_phi    = r_rd_data[3*W-1:2*W];
    assign rd_et     = r_rd_data[2*W-1:W];
    assign rd_e      = r_rd_data[W-1:0];

endmodule

// File: tb/tb_tower_event_collector.sv
// Directed bench for tower_event_collector: vector table for a basic event plus
// hand sequences for overflow, empty event, hold back-pressure, E check and reset.
module tb_tower_event_collector;

    localparam int unsigned W     = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_eta, in_phi, in_et, in_e;
    logic          in_last;
    logic [W-1:0]  threshold;
    logic [AW:0]   numtowers;
    logic          order;
    logic          overflow;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_eta, rd_phi, rd_et, rd_e;
    logic          ack;

    int n_cmp = 0;
    int n_err = 0;

    tower_event_collector #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_eta(in_eta), .in_phi(in_phi), .in_et(in_et), .in_e(in_e),
        .in_last(in_last), .threshold(threshold),
        .numtowers(numtowers), .order(order), .overflow(overflow),
        .rd_addr(rd_addr),
        .rd_eta(rd_eta), .rd_phi(rd_phi), .rd_et(rd_et), .rd_e(rd_e),
        .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [9:0] et;
        logic       last;
        logic [9:0] thr;
        int         exp_cnt;
        logic       exp_rdy;
        logic       exp_ord;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [9:0] et, input logic [9:0] e,
                        input logic last, input logic [9:0] thr, input logic [9:0] tag);
        in_valid  = v;
        in_et     = et;
        in_e      = e;
        in_last   = last;
        threshold = thr;
        in_eta    = tag;
        in_phi    = ~tag;
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input int exp_et, input int exp_eta,
                            input string name);
        rd_addr = a;
        step();
        chk({name, "_et"}, int'(rd_et), exp_et);
        chk({name, "_eta"}, int'(rd_eta), exp_eta);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        int exp_e;
        rst_n = 1'b0; in_valid = 1'b0; in_eta = '0; in_phi = '0; in_et = '0; in_e = '0;
        in_last = 1'b0; threshold = '0; rd_addr = '0; ack = 1'b0;

        vt[0] = '{1'b1, 10'd5,  1'b0, 10'd10, 0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 10'd20, 1'b0, 10'd10, 1, 1'b1, 1'b0};
        vt[2] = '{1'b1, 10'd3,  1'b0, 10'd10, 1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 10'd40, 1'b1, 10'd10, 2, 1'b0, 1'b1};
        vt[4] = '{1'b0, 10'd0,  1'b0, 10'd10, 2, 1'b0, 1'b0};
        vt[5] = '{1'b1, 10'd50, 1'b1, 10'd10, 2, 1'b0, 1'b0};

        // Reset values
        step(); step();
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_count", int'(numtowers), 0);
        chk("rst_order", int'(order), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_rd", int'({rd_eta, rd_phi, rd_et, rd_e}), 0);
        rst_n = 1'b1;
        chk("rel_ready_low", int'(in_ready), 0);
        step();
        chk("rel_ready_high", int'(in_ready), 1);

        // Basic event from the vector table
        for (int i = 0; i < 6; i++) begin
            beat(vt[i].valid, vt[i].et, 10'(vt[i].et + 10'd100), vt[i].last, vt[i].thr, 10'(i + 1));
            step();
            chk($sformatf("vec%0d_cnt", i), int'(numtowers), vt[i].exp_cnt);
            chk($sformatf("vec%0d_rdy", i), int'(in_ready), int'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_ord", i), int'(order), int'(vt[i].exp_ord));
        end
        beat(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
        read_chk(10'd0, 20, 2, "basic_rd0");
        read_chk(10'd1, 40, 4, "basic_rd1");
        do_ack();
        chk("basic_ack_rdy", int'(in_ready), 1);
        chk("basic_ack_cnt", int'(numtowers), 0);

        // Overflow: 1030 kept towers into a 1024-entry buffer
        for (int i = 0; i < 1030; i++) begin
            beat(1'b1, 10'(i), 10'd1023, (i == 1029), 10'd0, 10'(i));
            step();
            if (i == 1023) begin
                chk("ovf_full_cnt", int'(numtowers), 1024);
                chk("ovf_full_flag", int'(overflow), 0);
            end
            if (i == 1024) chk("ovf_set", int'(overflow), 1);
        end
        beat(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
        chk("ovf_cnt", int'(numtowers), 1024);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_order", int'(order), 1);
        read_chk(10'd0, 0, 0, "ovf_rd0");
        read_chk(10'd511, 511, 511, "ovf_rd511");
        read_chk(10'd1023, 1023, 1023, "ovf_rd1023");
        do_ack();
        chk("ovf_ack_cnt", int'(numtowers), 0);
        chk("ovf_ack_flag", int'(overflow), 0);

        // Empty event, then back-pressure in HOLD
        beat(1'b1, 10'd2, 10'd100, 1'b1, 10'd10, 10'd9);
        step();
        chk("empty_cnt", int'(numtowers), 0);
        chk("empty_order", int'(order), 1);
        chk("empty_rdy", int'(in_ready), 0);
        beat(1'b1, 10'd60, 10'd100, 1'b0, 10'd0, 10'd9);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold%0d_rdy", i), int'(in_ready), 0);
            chk($sformatf("hold%0d_ord", i), int'(order), 0);
        end
        chk("hold_cnt", int'(numtowers), 0);
        beat(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
        ack = 1'b1;
        chk("hold_pre_ack_rdy", int'(in_ready), 0);
        step();
        ack = 1'b0;
        chk("hold_ack_rdy", int'(in_ready), 1);

        // ack in COLLECT is ignored; then the E-check tower closes the event
        ack = 1'b1;
        beat(1'b1, 10'd15, 10'd100, 1'b0, 10'd0, 10'd11);
        step();
        ack = 1'b0;
        chk("collect_ack_cnt", int'(numtowers), 1);
        chk("collect_ack_rdy", int'(in_ready), 1);
        beat(1'b1, 10'd30, 10'd20, 1'b1, 10'd0, 10'd12);
        step();
`ifdef TOWER_E_CHECK_EN
        exp_e = 1;
`else
        exp_e = 2;
`endif
        chk("echeck_cnt", int'(numtowers), exp_e);
        chk("echeck_order", int'(order), 1);
        beat(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
        do_ack();

        // Reset in the middle of an event
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 10'd50, 10'd100, 1'b0, 10'd0, 10'(20 + i));
            step();
            chk($sformatf("mid%0d_ord", i), int'(order), 0);
        end
        chk("mid_cnt", int'(numtowers), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", int'(numtowers), 0);
        chk("mid_rst_rdy", int'(in_ready), 0);
        step(); step();
        chk("mid_rst_ord", int'(order), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", int'(in_ready), 1);
        chk("post_rst_ord", int'(order), 0);
        beat(1'b1, 10'd77, 10'd100, 1'b0, 10'd0, 10'd31);
        step();
        chk("post_rst_cnt1", int'(numtowers), 1);
        beat(1'b1, 10'd88, 10'd100, 1'b1, 10'd0, 10'd32);
        step();
        chk("post_rst_cnt2", int'(numtowers), 2);
        chk("post_rst_order", int'(order), 1);
        beat(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
        read_chk(10'd0, 77, 31, "post_rst_rd0");
        read_chk(10'd1, 88, 32, "post_rst_rd1");
        do_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
